// File: rtl/or1200_priv_monitor_pkg.sv
// rtl/or1200_priv_monitor_pkg.sv - shared tag value and channel FSM encoding for the privilege monitor
package or1200_priv_monitor_pkg;

  localparam logic [3:0] OR1200_DTAG_PE = 4'hc;

  typedef enum logic [1:0] {
    MON_IDLE = 2'd0,
    MON_WAIT = 2'd1,
    MON_MISS = 2'd2
  } mon_state_e;

endpackage

// File: rtl/or1200_priv_chan_mon.sv
// rtl/or1200_priv_chan_mon.sv - per-channel fault predicate, delivery window FSM and miss/spurious events
module or1200_priv_chan_mon
  import or1200_priv_monitor_pkg::*;
#(
  parameter int         MAX_LAT = 2,
  parameter logic [3:0] TAG_PE  = OR1200_DTAG_PE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       supv,
  input  logic       done,
  input  logic       we,
  input  logic       ure,
  input  logic       sre,
  input  logic       uwe,
  input  logic       swe,
  input  logic       err,
  input  logic [3:0] tag,
  input  logic       spur_en,
  output logic       miss_ev,
  output logic       spur_ev
);

  localparam int LW = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

  mon_state_e    state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          fault;
  logic          deliv;

  assign fault = done & ((~we & ~supv & ~ure) | (~we & supv & ~sre) |
                         ( we & ~supv & ~uwe) | ( we & supv & ~swe));
  assign deliv = err & (tag == TAG_PE);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    miss_ev = 1'b0;
    spur_ev = 1'b0;
    case (state_q)
      MON_IDLE: begin
        if (fault && !deliv) begin
          if (MAX_LAT == 0) begin
            state_d = MON_MISS;
          end else begin
            state_d = MON_WAIT;
            lat_d   = LW'(MAX_LAT);
          end
        end else if (!fault && deliv && spur_en) begin
          spur_ev = 1'b1;
        end
      end
      // further faults while waiting are absorbed into the open window
      MON_WAIT: begin
        if (deliv) begin
          state_d = MON_IDLE;
        end else if (lat_q == LW'(1)) begin
          state_d = MON_MISS;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      MON_MISS: begin
        miss_ev = 1'b1;
        state_d = MON_IDLE;
      end
      default: state_d = MON_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MON_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

endmodule

// File: rtl/or1200_priv_monitor.sv
// rtl/or1200_priv_monitor.sv - privilege-escalation monitor: channel monitors, supervisor consistency, sticky alarms, violation count
module or1200_priv_monitor
  import or1200_priv_monitor_pkg::*;
#(
  parameter int         NCH      = 2,
  parameter int         SUPV_W   = 3,
  parameter int         MAX_LAT  = 2,
  parameter int         CONS_TOL = 1,
  parameter int         CNT_W    = 8,
  parameter logic [3:0] TAG_PE   = OR1200_DTAG_PE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SUPV_W-1:0] secure_supv,
  input  logic [NCH-1:0]    ch_supv,
  input  logic [NCH-1:0]    ch_done,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH-1:0]    ch_ure,
  input  logic [NCH-1:0]    ch_sre,
  input  logic [NCH-1:0]    ch_uwe,
  input  logic [NCH-1:0]    ch_swe,
  input  logic [NCH-1:0]    ch_err,
  input  logic [4*NCH-1:0]  ch_tag,
  input  logic              spur_en,
  input  logic              clr,
  output logic [NCH-1:0]    miss_vec,
  output logic [NCH-1:0]    spur_vec,
  output logic              cons_err,
  output logic              alarm,
  output logic [CNT_W-1:0]  viol_cnt
);

  localparam int EW = $clog2(2 * NCH + 2);
  localparam int SW = CNT_W + EW;
  localparam int DW = $clog2(CONS_TOL + 2);

  logic           supv;
  logic [NCH-1:0] miss_ev;
  logic [NCH-1:0] spur_ev;
  logic           mismatch;
  logic           cons_ev;
  logic [DW-1:0]  dis_q;
  logic [EW-1:0]  ev_cnt;
  logic [CNT_W-1:0] cnt_base;
  logic [SW-1:0]  cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  assign supv = ^secure_supv;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    or1200_priv_chan_mon #(
      .MAX_LAT (MAX_LAT),
      .TAG_PE  (TAG_PE)
    ) u_mon (
      .clk     (clk),
      .rst     (rst),
      .supv    (supv),
      .done    (ch_done[g]),
      .we      (ch_we[g]),
      .ure     (ch_ure[g]),
      .sre     (ch_sre[g]),
      .uwe     (ch_uwe[g]),
      .swe     (ch_swe[g]),
      .err     (ch_err[g]),
      .tag     (ch_tag[4*g +: 4]),
      .spur_en (spur_en),
      .miss_ev (miss_ev[g]),
      .spur_ev (spur_ev[g])
    );
  end

  // the event fires on the cycle the run length crosses the tolerance; the counter then parks
  assign mismatch = |(ch_supv ^ {NCH{supv}});
  assign cons_ev  = mismatch && (dis_q == DW'(CONS_TOL));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dis_q <= '0;
    end else if (!mismatch) begin
      dis_q <= '0;
    end else if (dis_q != DW'(CONS_TOL + 1)) begin
      dis_q <= dis_q + DW'(1);
    end
  end

  always_comb begin
    ev_cnt = EW'(cons_ev);
    for (int i = 0; i < NCH; i++) begin
      ev_cnt = ev_cnt + EW'(miss_ev[i]) + EW'(spur_ev[i]);
    end
  end

  // clear and same-cycle events combine: the cleared base plus this cycle's events
  assign cnt_base = clr ? '0 : viol_cnt;
  assign cnt_sum  = SW'(cnt_base) + SW'(ev_cnt);
  assign cnt_next = (cnt_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_vec <= '0;
      spur_vec <= '0;
      cons_err <= 1'b0;
      alarm    <= 1'b0;
      viol_cnt <= '0;
    end else begin
      miss_vec <= (clr ? '0 : miss_vec) | miss_ev;
      spur_vec <= (clr ? '0 : spur_vec) | spur_ev;
      cons_err <= (clr ? 1'b0 : cons_err) | cons_ev;
      alarm    <= (|miss_vec) | (|spur_vec) | cons_err;
      viol_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_or1200_priv_monitor.sv
// tb/tb_or1200_priv_monitor.sv - self-checking bench with a deadline-based reference model
module tb_or1200_priv_monitor;

  localparam int         NCH      = 2;
  localparam int         SUPV_W   = 3;
  localparam int         MAX_LAT  = 2;
  localparam int         CONS_TOL = 1;
  localparam logic [3:0] TAG_PE   = 4'hc;

  logic              clk;
  logic              rst;
  logic [SUPV_W-1:0] secure_supv;
  logic [NCH-1:0]    ch_supv, ch_done, ch_we, ch_ure, ch_sre, ch_uwe, ch_swe, ch_err;
  logic [4*NCH-1:0]  ch_tag;
  logic              spur_en, clr;

  logic [NCH-1:0] a_miss_vec, a_spur_vec, b_miss_vec, b_spur_vec;
  logic           a_cons_err, a_alarm, b_cons_err, b_alarm;
  logic [7:0]     a_viol_cnt;
  logic [1:0]     b_viol_cnt;

  or1200_priv_monitor #(.NCH(NCH), .SUPV_W(SUPV_W), .MAX_LAT(MAX_LAT), .CONS_TOL(CONS_TOL),
                        .CNT_W(8), .TAG_PE(TAG_PE)) dut_a (
    .clk(clk), .rst(rst), .secure_supv(secure_supv), .ch_supv(ch_supv), .ch_done(ch_done),
    .ch_we(ch_we), .ch_ure(ch_ure), .ch_sre(ch_sre), .ch_uwe(ch_uwe), .ch_swe(ch_swe),
    .ch_err(ch_err), .ch_tag(ch_tag), .spur_en(spur_en), .clr(clr),
    .miss_vec(a_miss_vec), .spur_vec(a_spur_vec), .cons_err(a_cons_err), .alarm(a_alarm),
    .viol_cnt(a_viol_cnt));

  or1200_priv_monitor #(.NCH(NCH), .SUPV_W(SUPV_W), .MAX_LAT(MAX_LAT), .CONS_TOL(CONS_TOL),
                        .CNT_W(2), .TAG_PE(TAG_PE)) dut_b (
    .clk(clk), .rst(rst), .secure_supv(secure_supv), .ch_supv(ch_supv), .ch_done(ch_done),
    .ch_we(ch_we), .ch_ure(ch_ure), .ch_sre(ch_sre), .ch_uwe(ch_uwe), .ch_swe(ch_swe),
    .ch_err(ch_err), .ch_tag(ch_tag), .spur_en(spur_en), .clr(clr),
    .miss_vec(b_miss_vec), .spur_vec(b_spur_vec), .cons_err(b_cons_err), .alarm(b_alarm),
    .viol_cnt(b_viol_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an outstanding fault is a deadline cycle; a late one turns into a miss on the next cycle
  bit [NCH-1:0] e_miss, e_spur;
  bit           e_cons, e_alarm;
  int           e_cnt_a, e_cnt_b;
  bit           pend[NCH];
  int           dl[NCH];
  int           miss_at[NCH];
  int           run;
  int           cyc = 0;

  task model_reset();
    e_miss = '0; e_spur = '0; e_cons = 1'b0; e_alarm = 1'b0;
    e_cnt_a = 0; e_cnt_b = 0; run = 0;
    for (int i = 0; i < NCH; i++) begin
      pend[i] = 1'b0; dl[i] = 0; miss_at[i] = -1;
    end
  endtask

  task automatic model_step();
    bit s, perm, fault, deliv, cev;
    bit [NCH-1:0] mv, sv;
    int nev;
    s  = ^secure_supv;
    mv = '0;
    sv = '0;
    for (int i = 0; i < NCH; i++) begin
      perm  = s ? (ch_we[i] ? ch_swe[i] : ch_sre[i]) : (ch_we[i] ? ch_uwe[i] : ch_ure[i]);
      fault = ch_done[i] && !perm;
      deliv = ch_err[i] && (ch_tag[4*i +: 4] == TAG_PE);
      if (miss_at[i] == cyc) begin
        mv[i] = 1'b1;
        miss_at[i] = -1;
      end else if (pend[i]) begin
        if (deliv) pend[i] = 1'b0;
        else if (cyc == dl[i]) begin
          pend[i] = 1'b0;
          miss_at[i] = cyc + 1;
        end
      end else if (fault && !deliv) begin
        if (MAX_LAT == 0) miss_at[i] = cyc + 1;
        else begin
          pend[i] = 1'b1;
          dl[i] = cyc + MAX_LAT;
        end
      end else if (!fault && deliv && spur_en) begin
        sv[i] = 1'b1;
      end
    end
    run = (ch_supv != {NCH{s}}) ? run + 1 : 0;
    cev = (run == CONS_TOL + 1);
    nev = $countones(mv) + $countones(sv) + int'(cev);
    e_alarm = (|e_miss) || (|e_spur) || e_cons;
    if (clr) begin
      e_miss = '0; e_spur = '0; e_cons = 1'b0; e_cnt_a = 0; e_cnt_b = 0;
    end
    e_miss  = e_miss | mv;
    e_spur  = e_spur | sv;
    e_cons  = e_cons | cev;
    e_cnt_a = (e_cnt_a + nev > 255) ? 255 : e_cnt_a + nev;
    e_cnt_b = (e_cnt_b + nev > 3) ? 3 : e_cnt_b + nev;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst) model_reset();
    else model_step();
  end

  always @(negedge rst) model_reset();

  always @(negedge clk) begin
    if (check_en) begin
      chk("a_miss_vec", a_miss_vec, e_miss);
      chk("a_spur_vec", a_spur_vec, e_spur);
      chk("a_cons_err", a_cons_err, e_cons);
      chk("a_alarm",    a_alarm,    e_alarm);
      chk("a_viol_cnt", a_viol_cnt, e_cnt_a);
      chk("b_miss_vec", b_miss_vec, e_miss);
      chk("b_spur_vec", b_spur_vec, e_spur);
      chk("b_cons_err", b_cons_err, e_cons);
      chk("b_alarm",    b_alarm,    e_alarm);
      chk("b_viol_cnt", b_viol_cnt, e_cnt_b);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pin(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] lit);
    chk({name, "_dut"}, dut_v, lit);
    chk({name, "_model"}, mdl_v, lit);
  endtask

  initial begin
    rst = 1'b0; secure_supv = 3'b001; ch_supv = 2'b11;
    ch_done = '0; ch_we = '0; ch_ure = '1; ch_sre = '1; ch_uwe = '1; ch_swe = '1;
    ch_err = '0; ch_tag = '0; spur_en = 1'b0; clr = 1'b0;
    tick(2);
    rst = 1'b1;
    check_en = 1'b1;
    chk("reset_miss_vec", a_miss_vec, 0);
    chk("reset_viol_cnt", a_viol_cnt, 0);
    chk("reset_alarm", a_alarm, 0);

    // supervisor store on ch1 without write permission, PE delivered inside the window
    ch_done = 2'b10; ch_we = 2'b10; ch_swe = 2'b01;
    tick;
    ch_done = '0;
    tick;
    ch_err = 2'b10; ch_tag = 8'hc0;
    tick;
    ch_err = '0; ch_tag = '0;
    tick(3);
    pin("s1_miss", a_miss_vec, e_miss, 0);
    pin("s1_viol", a_viol_cnt, e_cnt_a, 0);
    pin("s1_alarm", a_alarm, e_alarm, 0);

    // same access, never delivered
    ch_done = 2'b10;
    tick;
    ch_done = '0;
    tick(3);
    pin("s2_miss", a_miss_vec, e_miss, 2);
    pin("s2_viol", a_viol_cnt, e_cnt_a, 1);
    pin("s2_alarm_lag", a_alarm, e_alarm, 0);
    tick;
    pin("s2_alarm", a_alarm, e_alarm, 1);
    clr = 1'b1; tick; clr = 1'b0; tick;
    ch_we = '0; ch_swe = '1;

    // unjustified PE on ch0, with and without spurious detection
    spur_en = 1'b1; ch_err = 2'b01; ch_tag = 8'h0c;
    tick;
    ch_err = '0;
    tick;
    pin("s3_spur", a_spur_vec, e_spur, 1);
    pin("s3_viol", a_viol_cnt, e_cnt_a, 1);
    clr = 1'b1; tick; clr = 1'b0; tick;
    spur_en = 1'b0; ch_err = 2'b01;
    tick;
    ch_err = '0; ch_tag = '0;
    tick;
    pin("s3_nospur", a_spur_vec, e_spur, 0);
    pin("s3_noviol", a_viol_cnt, e_cnt_a, 0);

    // ch1 claims user mode for three cycles while trusted mode is supervisor
    ch_supv = 2'b01;
    tick(3);
    ch_supv = 2'b11;
    tick;
    pin("s4_cons", a_cons_err, e_cons, 1);
    pin("s4_viol", a_viol_cnt, e_cnt_a, 1);
    tick(2);
    pin("s4_once", a_viol_cnt, e_cnt_a, 1);
    clr = 1'b1; tick; clr = 1'b0; tick;

    // five misses saturate the 2-bit counter; a PE during the miss cycle does not cancel it
    for (int r = 0; r < 3; r++) begin
      ch_done = (r == 2) ? 2'b01 : 2'b11;
      ch_sre  = ~ch_done;
      tick;
      ch_done = '0; ch_sre = '1;
      tick(2);
      if (r == 2) begin
        spur_en = 1'b1; ch_err = 2'b01; ch_tag = 8'h0c;
      end
      tick;
      spur_en = 1'b0; ch_err = '0; ch_tag = '0;
      tick;
    end
    pin("s5_sat_b", b_viol_cnt, e_cnt_b, 3);
    pin("s5_cnt_a", a_viol_cnt, e_cnt_a, 5);
    pin("s5_no_spur", a_spur_vec, e_spur, 0);
    pin("s5_miss", a_miss_vec, e_miss, 3);

    // clear in the same cycle as a new miss
    ch_done = 2'b01; ch_sre = 2'b10;
    tick;
    ch_done = '0; ch_sre = '1;
    tick(2);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    pin("s5_clr_miss", a_miss_vec, e_miss, 1);
    pin("s5_clr_viol_a", a_viol_cnt, e_cnt_a, 1);
    pin("s5_clr_viol_b", b_viol_cnt, e_cnt_b, 1);

    // asynchronous reset while ch0 waits for delivery
    ch_done = 2'b01; ch_sre = 2'b10;
    tick;
    ch_done = '0; ch_sre = '1;
    #2 rst = 1'b0;
    #1;
    chk("rst_async_miss", a_miss_vec, 0);
    chk("rst_async_viol", a_viol_cnt, 0);
    chk("rst_async_alarm", a_alarm, 0);
    chk("rst_async_viol_b", b_viol_cnt, 0);
    tick(2);
    rst = 1'b1;
    tick(5);
    pin("s6_miss", a_miss_vec, e_miss, 0);
    pin("s6_viol", a_viol_cnt, e_cnt_a, 0);
    pin("s6_alarm", a_alarm, e_alarm, 0);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/or1200_priv_monitor.md
Name: or1200_priv_monitor

Overview:
- Parametrised, sequential privilege-escalation monitor for OR1200 MMU channels (instruction, data, or added ports).
- Derives the trusted mode by XOR-reduction of a redundant supervisor encoding.
- For each access that must fault, requires a page-fault error with the PE tag within a bounded latency window. Also flags PE errors that no access justified, and supervisor-view disagreement that persists.
- Sits beside or1200_top. Outputs are registered, sticky alarms plus a saturating violation counter.

Parameters:
- NCH, 2, number of monitored MMU channels (ch 0 = IMMU by convention).
- SUPV_W, 3, width of the redundant supervisor encoding (trusted supv = XOR-reduce).
- MAX_LAT, 2, cycles after a fault-qualifying access within which err+PE tag must arrive (0 = same cycle only).
- CONS_TOL, 1, consecutive cycles of supervisor disagreement tolerated before alarm.
- CNT_W, 8, violation counter width.
- TAG_PE, `OR1200_DTAG_PE, tag value denoting a page-fault exception.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- secure_supv  in  SUPV_W  redundant supervisor encoding.
- ch_supv  in  NCH  per-channel MMU view of supervisor mode.
- ch_done  in  NCH  per-channel TLB lookup complete.
- ch_we  in  NCH  store access (tie 0 for instruction channels).
- ch_ure, ch_sre  in  NCH each  user/supv read (execute for IMMU) permission.
- ch_uwe, ch_swe  in  NCH each  user/supv write permission (ignored when ch_we=0).
- ch_err  in  NCH  MMU error asserted.
- ch_tag  in  4*NCH  exception tag per channel, channel i at [4i+3:4i].
- spur_en  in  1  enable spurious-PE detection.
- clr  in  1  synchronous clear of sticky flags and counter.
- miss_vec  out  NCH  sticky: expected fault not delivered in window.
- spur_vec  out  NCH  sticky: PE error with no pending expected fault.
- cons_err  out  1  sticky: supervisor views disagreed longer than CONS_TOL.
- alarm  out  1  registered OR of all sticky flags.
- viol_cnt  out  CNT_W  saturating count of violation events.

Behaviour:
- Reset (rst=0, async): all channel FSMs to IDLE; miss_vec, spur_vec, cons_err, alarm, viol_cnt = 0; disagreement counter = 0.
- Trusted supv s = XOR-reduce(secure_supv).
- Fault condition per channel: done & ((!we & !s & !ure) | (!we & s & !sre) | (we & !s & !uwe) | (we & s & !swe)).
- Delivery per channel: err & tag == TAG_PE.
- Channel FSM:
  - IDLE: fault & deliv -> IDLE (satisfied, no event). Fault & !deliv -> WAIT with lat_cnt = MAX_LAT; if MAX_LAT = 0, go to MISS directly. !fault & deliv & spur_en -> spurious event.
  - WAIT: deliv -> IDLE. Otherwise, lat_cnt == 1 -> MISS, else lat_cnt-1. New fault conditions in WAIT are absorbed; the window does not restart.
  - MISS: one cycle. Emits miss event, then returns to IDLE. Deliv in this cycle does not cancel the miss.
- Consistency: a mismatch exists when any ch_supv bit != s. dis_cnt increments on mismatch and resets to 0 on agreement. When dis_cnt reaches CONS_TOL+1, emit a consistency event once and hold dis_cnt saturated until agreement.
- Events set their sticky bit at the next clock edge. alarm follows one cycle later.
- viol_cnt adds the number of events in the cycle: misses + spurious + consistency, up to NCH*2+1. It saturates at all-ones and never wraps.
- clr: sticky bits and viol_cnt go to 0. Events in the same cycle as clr win: the bit is set and the count equals that cycle's event count. clr does not touch FSM state.
- Reset mid-WAIT discards the pending expectation; no miss is recorded.

Decomposition:
- TAG_PE and state encodings (IDLE=2'd0, WAIT=2'd1, MISS=2'd2) go in or1200_defines.v under a monitor section.
- One sub-module, or1200_priv_chan_mon: per-channel fault predicate, FSM, latency counter, miss/spur event outputs. Instantiate NCH times via generate.
- Top level holds supervisor XOR, consistency counter, sticky registers and the event adder/saturator.

Test Plan:
- NCH=2, MAX_LAT=2, secure_supv=3'b001 (s=1), ch1 done, we=1, swe=0; err+PE two cycles later -> no miss, viol_cnt=0, alarm=0.
- Same stimulus, no err for 3 cycles -> miss_vec=2'b10 on cycle 3, alarm=1 on cycle 4, viol_cnt=1.
- spur_en=1, ch0 err with tag=TAG_PE, no fault condition -> spur_vec=2'b01, viol_cnt=1. Repeat with spur_en=0 -> no flag.
- CONS_TOL=1, ch_supv=2'b01 while s=1 for 3 cycles -> cons_err=1 set exactly once, viol_cnt=1.
- CNT_W=2: force 5 miss events -> viol_cnt saturates at 3. Then clr together with a new miss -> miss bit set, viol_cnt=1.
- Enter WAIT on ch0, then assert rst low asynchronously mid-window -> all outputs 0 immediately. After release, no miss is reported.
